wb_grf: RTL and testbench
=========================

Name: wb_grf

Overview:
- Writeback stage plus general register file for the RV32I five-stage pipeline.
- It sits at the producer end of the GRF/forwarding interface. It captures MEM-stage results and performs load extraction and sign/zero extension.
- It commits to a 32x32 register file and serves the two decode read ports that feed the forwarding unit.
- It also exports the WB-stage write triple for bypass, and a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- INSTRET_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Stall_1  in  1  pipeline stall; holds the WB register and suppresses commit.
- MEM_Valid_1  in  1  MEM stage holds a real instruction (0 = bubble).
- MEM_GRFWen_1  in  1  the instruction writes rd.
- MEM_GRFWriteAddr_5  in  5  rd.
- MEM_GRFWriteData_32  in  32  non-load result (ALU/PC+4).
- MEM_Load_1  in  1  the instruction is a load.
- MEM_LoadType_3  in  3  load funct3.
- MEM_LoadAddrLow_2  in  2  effective address bits [1:0].
- MEM_LoadWord_32  in  32  raw aligned memory word.
- GRFReadAddr1_5 / GRFReadAddr2_5  in  5  decode read addresses.
- GRFReadData1_32 / GRFReadData2_32  out  32  read data.
- WB_GRFWen_1  out  1  WB holds a valid write with rd != 0.
- WB_GRFWriteAddr_5  out  5  WB rd.
- WB_GRFWriteData_32  out  32  WB final write data.
- WB_InstRet_64  out  INSTRET_W  count of retired instructions.

Behaviour:
- Reset (async, rst_n=0):
  - WB register cleared: valid 0, Wen 0, addr 0, data 0.
  - All 32 GRF entries cleared to 0.
  - WB_InstRet_64 = 0.
  - All outputs 0 during reset.
- Load extraction (combinational, MEM side):
  - LB=000: byte[addr] sign-extended.
  - LBU=100: byte[addr] zero-extended.
  - LH=001: half[addr[1]] sign-extended; addr[0] ignored.
  - LHU=101: half[addr[1]] zero-extended; addr[0] ignored.
  - LW=010 and reserved codes 011/110/111: full word.
  - Byte k occupies bits [8k+7:8k] (little-endian).
  - The extracted value replaces MEM_GRFWriteData_32 when MEM_Load_1=1.
- WB register (latency 1):
  - When Stall_1=0, on each posedge it captures valid, Wen, addr and final data.
  - A capture with MEM_Valid_1=0 loads a bubble (valid 0, Wen 0).
  - When Stall_1=1, the register holds.
- Commit: at posedge with Stall_1=0, WB valid, Wen=1 and addr != 0, GRF[addr] <= data. MEM-to-GRF visibility is therefore two edges.
- Retire counter:
  - Increments by 1 on each posedge with Stall_1=0 and WB valid, regardless of Wen.
  - Wraps modulo 2^INSTRET_W.
- Stall_1=1: no GRF write and no counter increment. The WB outputs remain stable and valid for forwarding.
- x0:
  - A write to address 0 is discarded.
  - WB_GRFWen_1 is forced to 0 when addr = 0.
  - Reads of address 0 always return 0, including under bypass.
- Read ports: combinational.
  - Priority is WB bypass (when enabled), then GRF array.
  - Both ports may read the same address simultaneously.
- Simultaneous events: a read of the same rd being committed that cycle returns the WB value via bypass. It never returns the stale array value when bypass is enabled.
- Reset mid-operation: an in-flight WB write is lost, and the GRF and counter are cleared immediately.

Optional Feature:
- Macro WB_GRF_BYPASS_EN.
- Defined: a read port whose address matches WB_GRFWriteAddr_5 while WB_GRFWen_1=1 returns WB_GRFWriteData_32 (write-through). The forwarding unit then needs only ALU and MEM sources.
- Undefined: reads return the array contents only. The new value is visible the cycle after commit. The external forwarding unit must add a WB source or stall.

Decomposition:
- Shared package contains:
  - Load funct3 constants (LB, LH, LW, LBU, LHU).
  - XLEN, GRF depth 32, address width 5.
  - The INSTRET_W default.
- One natural sub-module: load_ext, the combinational load extraction/extension driven from MEM inputs.
- The register array and WB register stay in wb_grf.

Test Plan:
- Reset check: hold rst_n=0, release it, read all 32 addresses -> every read returns 0, WB_InstRet_64=0, WB_GRFWen_1=0.
- Load extension: word 0x80FF7F01, LB at addr low 1 -> x5 gets 0x0000007F. At addr low 2, LB gives 0xFFFFFFFF. At addr low 3, LBU gives 0x00000080. LH at addr low 2 gives 0xFFFF80FF. LHU at addr low 0 gives 0x00007F01.
- x0 protection: write 0xDEADBEEF to addr 0 -> WB_GRFWen_1=0, and reads of address 0 return 0.
- Bypass (macro defined): WB commits 0x12345678 to x7 while GRFReadAddr1_5=7 in the same cycle -> GRFReadData1_32=0x12345678. Macro undefined -> the old value that cycle, 0x12345678 the next.
- Stall: the WB register holds an x3 write while Stall_1=1 for 3 cycles -> no GRF write, counter unchanged. After release, a single commit and counter +1.
- Retire count: 10 valid instructions (4 with Wen=0) and 5 bubbles with no stall -> WB_InstRet_64=10.

Source files
------------

// File: rtl/wb_grf_pkg.sv
// Shared constants and WB payload type for the writeback stage and register file.
package wb_grf_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned GRF_DEPTH     = 32;
  localparam int unsigned GRF_AW        = 5;
  localparam int unsigned INSTRET_W_DEF = 64;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic              valid;
    logic              wen;
    logic [GRF_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } wb_reg_t;

endpackage

// File: rtl/wb_grf_load_ext.sv
// Combinational load extraction: selects byte/half from an aligned word and extends it.
module wb_grf_load_ext
  import wb_grf_pkg::*;
(
  input  logic [2:0]      load_type_i,
  input  logic [1:0]      addr_low_i,
  input  logic [XLEN-1:0] word_i,
  output logic [XLEN-1:0] data_c_o
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c   = word_i[7:0];
    half_c   = addr_low_i[1] ? word_i[31:16] : word_i[15:0];
    data_c_o = word_i;
    case (addr_low_i)
      2'd1:    byte_c = word_i[15:8];
      2'd2:    byte_c = word_i[23:16];
      2'd3:    byte_c = word_i[31:24];
      default: byte_c = word_i[7:0];
    endcase
    // Reserved funct3 codes fall through to the full word.
    case (load_type_i)
      F3_LB:   data_c_o = {{(XLEN-8){byte_c[7]}}, byte_c};
      F3_LBU:  data_c_o = {{(XLEN-8){1'b0}}, byte_c};
      F3_LH:   data_c_o = {{(XLEN-16){half_c[15]}}, half_c};
      F3_LHU:  data_c_o = {{(XLEN-16){1'b0}}, half_c};
      default: data_c_o = word_i;
    endcase
  end

endmodule

// File: rtl/wb_grf.sv
// Writeback stage + 32x32 register file with two combinational read ports and retire counter.
// Optional WB->read-port write-through is enabled by defining WB_GRF_BYPASS_EN.
module wb_grf
  import wb_grf_pkg::*;
#(
  parameter int unsigned INSTRET_W = INSTRET_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 Stall_1,
  input  logic                 MEM_Valid_1,
  input  logic                 MEM_GRFWen_1,
  input  logic [GRF_AW-1:0]    MEM_GRFWriteAddr_5,
  input  logic [XLEN-1:0]      MEM_GRFWriteData_32,
  input  logic                 MEM_Load_1,
  input  logic [2:0]           MEM_LoadType_3,
  input  logic [1:0]           MEM_LoadAddrLow_2,
  input  logic [XLEN-1:0]      MEM_LoadWord_32,
  input  logic [GRF_AW-1:0]    GRFReadAddr1_5,
  input  logic [GRF_AW-1:0]    GRFReadAddr2_5,
  output logic [XLEN-1:0]      GRFReadData1_32,
  output logic [XLEN-1:0]      GRFReadData2_32,
  output logic                 WB_GRFWen_1,
  output logic [GRF_AW-1:0]    WB_GRFWriteAddr_5,
  output logic [XLEN-1:0]      WB_GRFWriteData_32,
  output logic [INSTRET_W-1:0] WB_InstRet_64
);

  logic [XLEN-1:0]      load_data_c;
  wb_reg_t              wb_d, wb_q;
  logic [INSTRET_W-1:0] instret_d, instret_q;
  logic [XLEN-1:0]      grf_q [GRF_DEPTH];
  logic                 commit_c;
  logic [XLEN-1:0]      rd1_c, rd2_c;

  wb_grf_load_ext u_load_ext (
    .load_type_i (MEM_LoadType_3),
    .addr_low_i  (MEM_LoadAddrLow_2),
    .word_i      (MEM_LoadWord_32),
    .data_c_o    (load_data_c)
  );

  // wen is stored pre-qualified (valid and rd != 0), so it alone gates commit.
  always_comb begin
    wb_d      = wb_q;
    instret_d = instret_q;
    commit_c  = 1'b0;
    if (!Stall_1) begin
      commit_c   = wb_q.wen;
      if (wb_q.valid) instret_d = instret_q + INSTRET_W'(1);
      wb_d.valid = MEM_Valid_1;
      wb_d.wen   = MEM_Valid_1 & MEM_GRFWen_1 & (MEM_GRFWriteAddr_5 != '0);
      wb_d.addr  = MEM_GRFWriteAddr_5;
      wb_d.data  = MEM_Load_1 ? load_data_c : MEM_GRFWriteData_32;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q      <= '0;
      instret_q <= '0;
    end else begin
      wb_q      <= wb_d;
      instret_q <= instret_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < GRF_DEPTH; i++) grf_q[i] <= '0;
    end else if (commit_c) begin
      grf_q[wb_q.addr] <= wb_q.data;
    end
  end

  // Read ports: optional WB write-through, x0 always reads zero.
  always_comb begin
    rd1_c = grf_q[GRFReadAddr1_5];
    rd2_c = grf_q[GRFReadAddr2_5];
`ifdef WB_GRF_BYPASS_EN
    if (wb_q.wen && (wb_q.addr == GRFReadAddr1_5)) rd1_c = wb_q.data;
    if (wb_q.wen && (wb_q.addr == GRFReadAddr2_5)) rd2_c = wb_q.data;
`else
    rd1_c = rd1_c;
    rd2_c = rd2_c;
`endif
    if (GRFReadAddr1_5 == '0) rd1_c = '0;
    if (GRFReadAddr2_5 == '0) rd2_c = '0;
  end

  assign GRFReadData1_32    = rd1_c;
  assign GRFReadData2_32    = rd2_c;
  assign WB_GRFWen_1        = wb_q.wen;
  assign WB_GRFWriteAddr_5  = wb_q.addr;
  assign WB_GRFWriteData_32 = wb_q.data;
  assign WB_InstRet_64      = instret_q;

endmodule

// File: tb/tb_wb_grf.sv
// Self-checking bench for wb_grf: per-cycle model comparison plus directed literal checks.
module tb_wb_grf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Stall_1 = 1'b0;
  logic        MEM_Valid_1 = 1'b0;
  logic        MEM_GRFWen_1 = 1'b0;
  logic [4:0]  MEM_GRFWriteAddr_5 = '0;
  logic [31:0] MEM_GRFWriteData_32 = '0;
  logic        MEM_Load_1 = 1'b0;
  logic [2:0]  MEM_LoadType_3 = '0;
  logic [1:0]  MEM_LoadAddrLow_2 = '0;
  logic [31:0] MEM_LoadWord_32 = '0;
  logic [4:0]  GRFReadAddr1_5 = '0;
  logic [4:0]  GRFReadAddr2_5 = '0;
  logic [31:0] GRFReadData1_32, GRFReadData2_32;
  logic        WB_GRFWen_1;
  logic [4:0]  WB_GRFWriteAddr_5;
  logic [31:0] WB_GRFWriteData_32;
  logic [63:0] WB_InstRet_64;

  int unsigned total = 0;
  int unsigned passed = 0;

  wb_grf #(.INSTRET_W(64)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .Stall_1             (Stall_1),
    .MEM_Valid_1         (MEM_Valid_1),
    .MEM_GRFWen_1        (MEM_GRFWen_1),
    .MEM_GRFWriteAddr_5  (MEM_GRFWriteAddr_5),
    .MEM_GRFWriteData_32 (MEM_GRFWriteData_32),
    .MEM_Load_1          (MEM_Load_1),
    .MEM_LoadType_3      (MEM_LoadType_3),
    .MEM_LoadAddrLow_2   (MEM_LoadAddrLow_2),
    .MEM_LoadWord_32     (MEM_LoadWord_32),
    .GRFReadAddr1_5      (GRFReadAddr1_5),
    .GRFReadAddr2_5      (GRFReadAddr2_5),
    .GRFReadData1_32     (GRFReadData1_32),
    .GRFReadData2_32     (GRFReadData2_32),
    .WB_GRFWen_1         (WB_GRFWen_1),
    .WB_GRFWriteAddr_5   (WB_GRFWriteAddr_5),
    .WB_GRFWriteData_32  (WB_GRFWriteData_32),
    .WB_InstRet_64       (WB_InstRet_64)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_grf [32] = '{default: '0};
  bit          m_valid = 1'b0;
  bit          m_wen = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic [63:0] m_cnt = '0;

  function automatic logic [31:0] m_ext(input logic [2:0] t, input logic [1:0] a, input logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * int'(a))) & 32'hFF;
    h = (w >> (16 * int'(a[1]))) & 32'hFFFF;
    case (t)
      3'b000:  return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic bit m_wb_wen();
    return m_valid && m_wen && (m_addr != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef WB_GRF_BYPASS_EN
    if (m_wb_wen() && (m_addr == a)) return m_data;
`endif
    return m_grf[a];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_grf[i] = '0;
      m_valid = 1'b0; m_wen = 1'b0; m_addr = '0; m_data = '0; m_cnt = '0;
    end else if (!Stall_1) begin
      if (m_valid) begin
        m_cnt = m_cnt + 64'd1;
        if (m_wen && m_addr != 5'd0) m_grf[m_addr] = m_data;
      end
      m_valid = MEM_Valid_1;
      m_wen   = MEM_Valid_1 && MEM_GRFWen_1;
      m_addr  = MEM_GRFWriteAddr_5;
      m_data  = MEM_Load_1 ? m_ext(MEM_LoadType_3, MEM_LoadAddrLow_2, MEM_LoadWord_32)
                           : MEM_GRFWriteData_32;
    end
  end

  // Per-cycle compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    chk("cmp_rd1", 64'(GRFReadData1_32), 64'(m_read(GRFReadAddr1_5)));
    chk("cmp_rd2", 64'(GRFReadData2_32), 64'(m_read(GRFReadAddr2_5)));
    chk("cmp_wen", 64'(WB_GRFWen_1), 64'(m_wb_wen()));
    chk("cmp_instret", WB_InstRet_64, m_cnt);
    if (m_wb_wen()) begin
      chk("cmp_wb_addr", 64'(WB_GRFWriteAddr_5), 64'(m_addr));
      chk("cmp_wb_data", 64'(WB_GRFWriteData_32), 64'(m_data));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem(input bit v, input bit we, input logic [4:0] rd, input logic [31:0] d,
                     input bit ld, input logic [2:0] t, input logic [1:0] al, input logic [31:0] w);
    MEM_Valid_1         = v;
    MEM_GRFWen_1        = we;
    MEM_GRFWriteAddr_5  = rd;
    MEM_GRFWriteData_32 = d;
    MEM_Load_1          = ld;
    MEM_LoadType_3      = t;
    MEM_LoadAddrLow_2   = al;
    MEM_LoadWord_32     = w;
  endtask

  task automatic bubble();
    mem(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0, 32'd0);
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    GRFReadAddr1_5 = a1;
    GRFReadAddr2_5 = a2;
    #1;
  endtask

  localparam logic [31:0] LW_WORD = 32'h80FF_7F01;

  initial begin
    // Reset
    repeat (3) tick();
    chk("rst_wen", 64'(WB_GRFWen_1), 64'd0);
    chk("rst_instret", WB_InstRet_64, 64'd0);
    chk("rst_wb_data", 64'(WB_GRFWriteData_32), 64'd0);
    rst_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      rd(5'(a), 5'(31 - a));
      chk("rst_read1", 64'(GRFReadData1_32), 64'd0);
      chk("rst_read2", 64'(GRFReadData2_32), 64'd0);
    end
    chk("rst_instret_after", WB_InstRet_64, 64'd0);

    // Retire count: 10 valid (4 without Wen) and 5 bubbles
    for (int i = 0; i < 15; i++) begin
      if (i % 3 == 2) bubble();
      else mem(1'b1, !((i % 3 == 1) && (i < 12)), 5'(16 + i), 32'(i) * 32'h0101_0101,
               1'b0, 3'd0, 2'd0, 32'd0);
      tick();
    end
    bubble();
    tick();
    chk("retire_count", WB_InstRet_64, 64'd10);
    rd(5'd16, 5'd17);
    chk("retire_x16", 64'(GRFReadData1_32), 64'd0);
    chk("retire_x17_nowen", 64'(GRFReadData2_32), 64'd0);
    rd(5'd19, 5'd29);
    chk("retire_x19", 64'(GRFReadData1_32), 64'h0303_0303);
    chk("retire_x29", 64'(GRFReadData2_32), 64'h0D0D_0D0D);

    // Load extraction / extension
    mem(1'b1, 1'b1, 5'd5, 32'hAAAA_AAAA, 1'b1, 3'b000, 2'd1, LW_WORD); tick();
    chk("lb_a1_wb", 64'(WB_GRFWriteData_32), 64'h0000_007F);
    mem(1'b1, 1'b1, 5'd6, 32'hAAAA_AAAA, 1'b1, 3'b000, 2'd2, LW_WORD); tick();
    chk("lb_a2_wb", 64'(WB_GRFWriteData_32), 64'hFFFF_FFFF);
    mem(1'b1, 1'b1, 5'd8, 32'hAAAA_AAAA, 1'b1, 3'b100, 2'd3, LW_WORD); tick();
    chk("lbu_a3_wb", 64'(WB_GRFWriteData_32), 64'h0000_0080);
    mem(1'b1, 1'b1, 5'd9, 32'hAAAA_AAAA, 1'b1, 3'b001, 2'd2, LW_WORD); tick();
    chk("lh_a2_wb", 64'(WB_GRFWriteData_32), 64'hFFFF_80FF);
    mem(1'b1, 1'b1, 5'd10, 32'hAAAA_AAAA, 1'b1, 3'b101, 2'd0, LW_WORD); tick();
    chk("lhu_a0_wb", 64'(WB_GRFWriteData_32), 64'h0000_7F01);
    mem(1'b1, 1'b1, 5'd11, 32'hAAAA_AAAA, 1'b1, 3'b010, 2'd3, LW_WORD); tick();
    chk("lw_wb", 64'(WB_GRFWriteData_32), 64'h80FF_7F01);
    mem(1'b1, 1'b1, 5'd12, 32'hAAAA_AAAA, 1'b1, 3'b111, 2'd1, LW_WORD); tick();
    chk("lres_wb", 64'(WB_GRFWriteData_32), 64'h80FF_7F01);
    bubble(); tick();
    rd(5'd5, 5'd6);
    chk("lb_x5", 64'(GRFReadData1_32), 64'h0000_007F);
    chk("lb_x6", 64'(GRFReadData2_32), 64'hFFFF_FFFF);
    rd(5'd8, 5'd9);
    chk("lbu_x8", 64'(GRFReadData1_32), 64'h0000_0080);
    chk("lh_x9", 64'(GRFReadData2_32), 64'hFFFF_80FF);
    rd(5'd10, 5'd10);
    chk("lhu_x10_p1", 64'(GRFReadData1_32), 64'h0000_7F01);
    chk("lhu_x10_p2", 64'(GRFReadData2_32), 64'h0000_7F01);
    chk("load_instret", WB_InstRet_64, 64'd17);

    // x0 protection
    mem(1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 3'd0, 2'd0, 32'd0); tick();
    chk("x0_wen", 64'(WB_GRFWen_1), 64'd0);
    rd(5'd0, 5'd0);
    chk("x0_read_inflight", 64'(GRFReadData1_32), 64'd0);
    bubble(); tick();
    rd(5'd0, 5'd0);
    chk("x0_read1", 64'(GRFReadData1_32), 64'd0);
    chk("x0_read2", 64'(GRFReadData2_32), 64'd0);
    chk("x0_instret", WB_InstRet_64, 64'd18);

    // Same-cycle commit and read of x7
    mem(1'b1, 1'b1, 5'd7, 32'h1111_1111, 1'b0, 3'd0, 2'd0, 32'd0); tick();
    bubble(); tick();
    mem(1'b1, 1'b1, 5'd7, 32'h1234_5678, 1'b0, 3'd0, 2'd0, 32'd0); tick();
    rd(5'd7, 5'd7);
`ifdef WB_GRF_BYPASS_EN
    chk("bypass_same_cycle", 64'(GRFReadData1_32), 64'h1234_5678);
`else
    chk("nobypass_same_cycle", 64'(GRFReadData1_32), 64'h1111_1111);
`endif
    bubble(); tick();
    chk("x7_next_cycle", 64'(GRFReadData1_32), 64'h1234_5678);
    chk("bypass_instret", WB_InstRet_64, 64'd20);

    // Stall holds the WB x3 write for 3 cycles
    mem(1'b1, 1'b1, 5'd3, 32'h3333_3333, 1'b0, 3'd0, 2'd0, 32'd0); tick();
    Stall_1 = 1'b1;
    mem(1'b1, 1'b1, 5'd4, 32'h4444_4444, 1'b0, 3'd0, 2'd0, 32'd0);
    repeat (3) tick();
    chk("stall_wen", 64'(WB_GRFWen_1), 64'd1);
    chk("stall_addr", 64'(WB_GRFWriteAddr_5), 64'd3);
    chk("stall_data", 64'(WB_GRFWriteData_32), 64'h3333_3333);
    chk("stall_instret", WB_InstRet_64, 64'd20);
    rd(5'd3, 5'd4);
`ifdef WB_GRF_BYPASS_EN
    chk("stall_x3", 64'(GRFReadData1_32), 64'h3333_3333);
`else
    chk("stall_x3", 64'(GRFReadData1_32), 64'd0);
`endif
    Stall_1 = 1'b0;
    bubble(); tick();
    rd(5'd3, 5'd4);
    chk("release_x3", 64'(GRFReadData1_32), 64'h3333_3333);
    chk("release_x4", 64'(GRFReadData2_32), 64'd0);
    chk("release_instret", WB_InstRet_64, 64'd21);
    tick();
    chk("release_single", WB_InstRet_64, 64'd21);

    // Reset mid-operation drops the in-flight write
    mem(1'b1, 1'b1, 5'd9, 32'h9999_9999, 1'b0, 3'd0, 2'd0, 32'd0); tick();
    rst_n = 1'b0;
    rd(5'd5, 5'd9);
    chk("midrst_wen", 64'(WB_GRFWen_1), 64'd0);
    chk("midrst_instret", WB_InstRet_64, 64'd0);
    chk("midrst_x5", 64'(GRFReadData1_32), 64'd0);
    chk("midrst_x9", 64'(GRFReadData2_32), 64'd0);
    bubble(); tick();
    rst_n = 1'b1;
    repeat (2) tick();
    rd(5'd9, 5'd3);
    chk("postrst_x9", 64'(GRFReadData1_32), 64'd0);
    chk("postrst_x3", 64'(GRFReadData2_32), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
